// File: rtl/leg_mem_pkg.sv
`default_nettype none
// ============================================================================
// Module      : leg_mem_pkg
// Description : Shared types and helpers for the cache line memory controller.
// Revision    : 1.0 - initial release
// ============================================================================
package leg_mem_pkg;

    // Controller states; explicit 2-bit encoding.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Bytes per memory word; word addresses step by this amount.
    localparam int unsigned WORD_BYTES = 4;

    // Align a byte address down to the start of its cache line.
    function automatic logic [31:0] lineBase(input logic [31:0] addr,
                                             input int unsigned blocksize);
        logic [31:0] mask;
        mask = 32'(blocksize * WORD_BYTES) - 32'd1;
        return addr & ~mask;
    endfunction

endpackage
`default_nettype wire

// File: rtl/cache_line_mem_ctrl_line_addr_gen.sv
`default_nettype none
// ============================================================================
// Module      : line_addr_gen
// Description : Word counter within a cache line plus memory address
//               generation (a = base + cnt * WORD_BYTES). The counter wraps
//               modulo BLOCKSIZE; last_o flags the final word of the burst,
//               i.e. the word whose successor is the starting word.
// Revision    : 1.0 - initial release
// ============================================================================
module line_addr_gen
    import leg_mem_pkg::*;
#(
    parameter int BLOCKSIZE = 4,
    parameter int CW        = $clog2(BLOCKSIZE)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          load_i,
    input  logic [CW-1:0] start_i,
    input  logic          inc_i,
    input  logic [31:0]   base_i,
    output logic [CW-1:0] cnt_o,
    output logic          last_o,
    output logic [31:0]   addr_o
);

    localparam logic [CW-1:0] C_ONE = CW'(1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] start_q, start_d;
    logic [CW-1:0] w_cnt_inc;

    // Natural CW-bit overflow provides the modulo-BLOCKSIZE wrap.
    assign w_cnt_inc = cnt_q + C_ONE;

    // Next counter value: load on accept, step on each completed word.
    always_comb begin
        cnt_d   = cnt_q;
        start_d = start_q;
        if (load_i) begin
            cnt_d   = start_i;
            start_d = start_i;
        end else if (inc_i) begin
            cnt_d = w_cnt_inc;
        end
    end

    // Counter and starting-word registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q   <= '0;
            start_q <= '0;
        end else begin
            cnt_q   <= cnt_d;
            start_q <= start_d;
        end
    end

    assign cnt_o  = cnt_q;
    assign last_o = (w_cnt_inc == start_q);
    assign addr_o = base_i + 32'(cnt_q) * 32'(WORD_BYTES);

endmodule
`default_nettype wire

// File: rtl/cache_line_mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : cache_line_mem_ctrl
// Description : Bus initiator converting one cache line fill / writeback into
//               BLOCKSIZE single-word memory transactions, returning the
//               assembled fill line with a one-cycle resp_valid pulse.
//               Optional macro CRITICAL_WORD_FIRST_EN: fills begin at the
//               requested word and wrap; writebacks always begin at word 0.
// Revision    : 1.0 - initial release
// ============================================================================
module cache_line_mem_ctrl
    import leg_mem_pkg::*;
#(
    parameter int BLOCKSIZE = 4,
    parameter int WORD_W    = 32
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        req_valid,
    input  logic                        req_write,
    input  logic [31:0]                 req_addr,
    input  logic [BLOCKSIZE*WORD_W-1:0] req_wdata,
    output logic                        req_ready,
    output logic                        resp_valid,
    output logic [BLOCKSIZE*WORD_W-1:0] resp_rdata,
    output logic                        we,
    output logic                        re,
    output logic                        HSEL,
    output logic [31:0]                 a,
    output logic [WORD_W-1:0]           wd,
    input  logic [WORD_W-1:0]           rd,
    input  logic                        Valid
);

    localparam int CW = $clog2(BLOCKSIZE);
    localparam int LW = BLOCKSIZE * WORD_W;

    state_t        state_q, state_d;
    logic [31:0]   base_q, base_d;
    logic [LW-1:0] wline_q, wline_d;
    logic [LW-1:0] fill_q, fill_d;
    logic [LW-1:0] resp_q, resp_d;

    logic          w_accept;
    logic          w_inc;
    logic          w_last;
    logic [CW-1:0] w_start;
    logic [CW-1:0] w_cnt;
    logic [31:0]   w_addr;

    assign w_accept = (state_q == IDLE) && req_valid;
    assign w_inc    = ((state_q == READ) || (state_q == WRITE)) && Valid;

`ifdef CRITICAL_WORD_FIRST_EN
    assign w_start = req_write ? '0 : req_addr[CW+1:2];
`else
    assign w_start = '0;
`endif

    line_addr_gen #(
        .BLOCKSIZE (BLOCKSIZE),
        .CW        (CW)
    ) u_addr_gen (
        .clk     (clk),
        .reset   (reset),
        .load_i  (w_accept),
        .start_i (w_start),
        .inc_i   (w_inc),
        .base_i  (base_q),
        .cnt_o   (w_cnt),
        .last_o  (w_last),
        .addr_o  (w_addr)
    );

    // Next-state and bus/handshake outputs; idle values are the defaults.
    always_comb begin
        state_d    = state_q;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        we         = 1'b0;
        re         = 1'b0;
        HSEL       = 1'b0;
        a          = '0;
        wd         = '0;
        case (state_q)
            IDLE: begin
                req_ready = ~reset;
                if (req_valid) begin
                    state_d = req_write ? WRITE : READ;
                end
            end
            READ: begin
                HSEL = 1'b1;
                re   = 1'b1;
                a    = w_addr;
                if (Valid && w_last) begin
                    state_d = DONE;
                end
            end
            WRITE: begin
                HSEL = 1'b1;
                we   = 1'b1;
                a    = w_addr;
                wd   = wline_q[int'(w_cnt)*WORD_W +: WORD_W];
                if (Valid && w_last) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                resp_valid = 1'b1;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Line buffers: latch request, collect fill words, publish on last word.
    always_comb begin
        base_d  = base_q;
        wline_d = wline_q;
        fill_d  = fill_q;
        resp_d  = resp_q;
        if (w_accept) begin
            base_d  = lineBase(req_addr, BLOCKSIZE);
            wline_d = req_wdata;
        end
        if ((state_q == READ) && Valid) begin
            fill_d[int'(w_cnt)*WORD_W +: WORD_W] = rd;
            if (w_last) begin
                resp_d = fill_d;
            end
        end
    end

    // State and buffer registers; reset abandons any transfer in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            base_q  <= '0;
            wline_q <= '0;
            fill_q  <= '0;
            resp_q  <= '0;
        end else begin
            state_q <= state_d;
            base_q  <= base_d;
            wline_q <= wline_d;
            fill_q  <= fill_d;
            resp_q  <= resp_d;
        end
    end

    assign resp_rdata = resp_q;

endmodule
`default_nettype wire

// File: tb/tb_cache_line_mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_cache_line_mem_ctrl
// Description : Directed self-checking bench for cache_line_mem_ctrl with a
//               small word memory model (rd combinational from a).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cache_line_mem_ctrl;

    localparam int BLOCKSIZE = 4;
    localparam int WORD_W    = 32;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         req_valid = 1'b0;
    logic         req_write = 1'b0;
    logic [31:0]  req_addr = '0;
    logic [127:0] req_wdata = '0;
    logic         req_ready, resp_valid, we, re, HSEL;
    logic [127:0] resp_rdata;
    logic [31:0]  a, wd, rd;
    logic         Valid = 1'b1;

    int checks = 0;
    int errors = 0;

    // Memory model: 16 words indexed by {a[13:12], a[3:2]}
    logic [31:0] mem [16];
    logic        pl_en = 1'b0;
    logic [3:0]  pl_idx = '0;
    logic [31:0] pl_data = '0;

    always #5 clk = ~clk;

    assign rd = mem[{a[13:12], a[3:2]}];

    always @(posedge clk) begin
        if (pl_en) mem[pl_idx] <= pl_data;
        else if (HSEL && we && Valid) mem[{a[13:12], a[3:2]}] <= wd;
    end

    cache_line_mem_ctrl #(.BLOCKSIZE(BLOCKSIZE), .WORD_W(WORD_W)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(req_ready),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .we(we), .re(re),
        .HSEL(HSEL), .a(a), .wd(wd), .rd(rd), .Valid(Valid)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input logic [3:0] idx, input logic [31:0] d);
        pl_en = 1'b1; pl_idx = idx; pl_data = d;
        tick();
        pl_en = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        tick(); tick(); tick();
        checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL rst_ready_hi got %b exp 0", req_ready); end
        checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL rst_resp_hi got %b exp 0", resp_valid); end
        reset = 1'b0;
        #1;
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL rst_ready_lo got %b exp 1", req_ready); end
        checks++; if (resp_rdata !== 128'h0) begin errors++; $display("FAIL rst_rdata got %h exp 0", resp_rdata); end
        checks++; if ({HSEL, re, we} !== 3'b000) begin errors++; $display("FAIL rst_bus got %b exp 000", {HSEL, re, we}); end
        checks++; if (a !== 32'h0 || wd !== 32'h0) begin errors++; $display("FAIL rst_a_wd got %h/%h exp 0/0", a, wd); end
    endtask

    task automatic test_fill;
        logic [31:0] ea [4];
`ifdef CRITICAL_WORD_FIRST_EN
        ea = '{32'h1008, 32'h100C, 32'h1000, 32'h1004};
`else
        ea = '{32'h1000, 32'h1004, 32'h1008, 32'h100C};
`endif
        req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h1008; Valid = 1'b1;
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL fill_ready got %b exp 1", req_ready); end
        tick();
        req_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            checks++; if (a !== ea[i]) begin errors++; $display("FAIL fill_a%0d got %h exp %h", i, a, ea[i]); end
            checks++; if ({HSEL, re, we, resp_valid} !== 4'b1100) begin errors++; $display("FAIL fill_ctl%0d got %b exp 1100", i, {HSEL, re, we, resp_valid}); end
            tick();
        end
        checks++; if (resp_valid !== 1'b1 || req_ready !== 1'b0) begin errors++; $display("FAIL fill_done got rv=%b rr=%b exp 1/0", resp_valid, req_ready); end
        checks++; if (resp_rdata !== {32'h44, 32'h33, 32'h22, 32'h11}) begin errors++; $display("FAIL fill_rdata got %h", resp_rdata); end
        tick();
        checks++; if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin errors++; $display("FAIL fill_idle got rv=%b rr=%b exp 0/1", resp_valid, req_ready); end
        checks++; if (resp_rdata !== {32'h44, 32'h33, 32'h22, 32'h11}) begin errors++; $display("FAIL fill_hold got %h", resp_rdata); end
    endtask

    task automatic test_writeback;
        logic [31:0] w [4];
        w = '{32'hAAAA_0001, 32'hBBBB_0002, 32'hCCCC_0003, 32'hDDDD_0004};
        req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h2004;
        req_wdata = {w[3], w[2], w[1], w[0]}; Valid = 1'b1;
        tick();
        req_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            checks++; if (a !== 32'h2000 + 32'(4*i) || wd !== w[i]) begin errors++; $display("FAIL wb_pair%0d got %h/%h exp %h/%h", i, a, wd, 32'h2000 + 32'(4*i), w[i]); end
            checks++; if ({HSEL, we, re, resp_valid} !== 4'b1100) begin errors++; $display("FAIL wb_ctl%0d got %b exp 1100", i, {HSEL, we, re, resp_valid}); end
            tick();
        end
        checks++; if (resp_valid !== 1'b1) begin errors++; $display("FAIL wb_done got %b exp 1", resp_valid); end
        checks++; if (resp_rdata !== {32'h44, 32'h33, 32'h22, 32'h11}) begin errors++; $display("FAIL wb_rdata_kept got %h", resp_rdata); end
        tick();
        req_write = 1'b0;
        for (int i = 0; i < 4; i++) begin
            checks++; if (mem[8+i] !== w[i]) begin errors++; $display("FAIL wb_mem%0d got %h exp %h", i, mem[8+i], w[i]); end
        end
    endtask

    task automatic test_wait_states;
        logic [31:0] ea [8];
        ea = '{32'h0, 32'h1000, 32'h1004, 32'h1004, 32'h1004, 32'h1004, 32'h1008, 32'h100C};
        preload(4'd4, 32'h55); preload(4'd5, 32'h66); preload(4'd6, 32'h77); preload(4'd7, 32'h88);
        req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h1000; Valid = 1'b1;
        tick();
        req_valid = 1'b0;
        for (int c = 1; c <= 7; c++) begin
            Valid = (c >= 2 && c <= 4) ? 1'b0 : 1'b1;
            checks++; if (a !== ea[c] || re !== 1'b1) begin errors++; $display("FAIL ws_a_c%0d got %h re=%b exp %h", c, a, re, ea[c]); end
            checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL ws_early_c%0d got %b exp 0", c, resp_valid); end
            tick();
        end
        Valid = 1'b1;
        checks++; if (resp_valid !== 1'b1) begin errors++; $display("FAIL ws_done got %b exp 1", resp_valid); end
        checks++; if (resp_rdata !== {32'h88, 32'h77, 32'h66, 32'h55}) begin errors++; $display("FAIL ws_rdata got %h", resp_rdata); end
        tick();
    endtask

    task automatic test_reset_mid;
        req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h1000; Valid = 1'b1;
        tick();
        req_valid = 1'b0;
        tick(); tick();
        checks++; if (a !== 32'h1008) begin errors++; $display("FAIL rm_word2 got %h exp 1008", a); end
        reset = 1'b1;
        #1;
        checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL rm_ready_hi got %b exp 0", req_ready); end
        tick();
        reset = 1'b0;
        #1;
        checks++; if ({HSEL, re, resp_valid} !== 3'b000) begin errors++; $display("FAIL rm_idle got %b exp 000", {HSEL, re, resp_valid}); end
        checks++; if (req_ready !== 1'b1 || resp_rdata !== 128'h0) begin errors++; $display("FAIL rm_clear got rr=%b rdata=%h", req_ready, resp_rdata); end
        tick();
        checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL rm_no_resp got %b exp 0", resp_valid); end
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            checks++; if (a !== 32'h1000 + 32'(4*i) || re !== 1'b1) begin errors++; $display("FAIL rm_refill_a%0d got %h re=%b", i, a, re); end
            tick();
        end
        checks++; if (resp_valid !== 1'b1) begin errors++; $display("FAIL rm_refill_done got %b exp 1", resp_valid); end
        checks++; if (resp_rdata !== {32'h88, 32'h77, 32'h66, 32'h55}) begin errors++; $display("FAIL rm_refill_rdata got %h", resp_rdata); end
        tick();
    endtask

    task automatic test_back_to_back;
        req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h1000; Valid = 1'b1;
        tick();
        for (int c = 1; c <= 4; c++) begin
            checks++; if (a !== 32'h1000 + 32'(4*(c-1)) || re !== 1'b1) begin errors++; $display("FAIL b2b_first_c%0d got %h re=%b", c, a, re); end
            tick();
        end
        checks++; if (resp_valid !== 1'b1 || req_ready !== 1'b0 || re !== 1'b0) begin errors++; $display("FAIL b2b_done got rv=%b rr=%b re=%b exp 1/0/0", resp_valid, req_ready, re); end
        tick();
        checks++; if (req_ready !== 1'b1 || {HSEL, re, resp_valid} !== 3'b000) begin errors++; $display("FAIL b2b_gap got rr=%b bus=%b", req_ready, {HSEL, re, resp_valid}); end
        tick();
        req_valid = 1'b0;
        for (int c = 7; c <= 10; c++) begin
            checks++; if (a !== 32'h1000 + 32'(4*(c-7)) || re !== 1'b1 || resp_valid !== 1'b0) begin errors++; $display("FAIL b2b_second_c%0d got %h re=%b rv=%b", c, a, re, resp_valid); end
            tick();
        end
        checks++; if (resp_valid !== 1'b1) begin errors++; $display("FAIL b2b_second_done got %b exp 1", resp_valid); end
        checks++; if (resp_rdata !== {32'h88, 32'h77, 32'h66, 32'h55}) begin errors++; $display("FAIL b2b_rdata got %h", resp_rdata); end
        tick();
        checks++; if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin errors++; $display("FAIL b2b_end got rv=%b rr=%b", resp_valid, req_ready); end
    endtask

    initial begin
        test_reset();
        preload(4'd4, 32'h11); preload(4'd5, 32'h22); preload(4'd6, 32'h33); preload(4'd7, 32'h44);
        test_fill();
        test_writeback();
        test_wait_states();
        test_reset_mid();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
